// File: rtl/wb_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_cmd_pkg
// Description : Shared definitions for the Wishbone command master: FSM state
//               encoding, timeout response data and the default timeout.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package wb_cmd_pkg;

    // Width of the bus-cycle timeout counter.
    localparam int unsigned c_CNT_W = 16;

    // Default number of bus cycles without an ack before a transfer aborts.
    localparam int unsigned c_DEFAULT_TIMEOUT_CYCLES = 255;

    // Read data returned with a timed-out transfer.
    localparam logic [31:0] c_TIMEOUT_DATA = 32'hDEAD_BEEF;

    // Explicit 2-bit state encodings.
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUS  = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_BUS  = c_ST_BUS,
        ST_RESP = c_ST_RESP
    } state_t;

endpackage : wb_cmd_pkg
`default_nettype wire

// File: rtl/wb_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : wb_timeout_cnt
// Description : Saturating up-counter that flags when the number of counted
//               cycles has reached a programmable limit.
// Ports       : clk     - clock, rising edge
//               rst     - synchronous active-high reset
//               clr     - synchronous clear of the count
//               en      - count enable (one increment per cycle)
//               limit   - count value at which expired asserts
//               expired - high while count >= limit
// Revision    : 1.0 - initial release
// ============================================================================
module wb_timeout_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;

    // Count holds at all-ones rather than wrapping back to zero, so a very
    // long stall can never masquerade as a fresh transfer.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en && (r_count != c_MAX)) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign expired = (r_count >= limit);

endmodule : wb_timeout_cnt
`default_nettype wire

// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_cmd_master
// Description : Single-transfer command-to-Wishbone bridge. Accepts one
//               command, runs one classic Wishbone cycle with a timeout, and
//               returns the read data / error flag on a valid-ready response.
// Ports       : wb_clk_i, wb_rst_i          - clock, synchronous reset
//               cmd_valid_i/cmd_ready_o     - command handshake
//               cmd_we_i/adr_i/dat_i/sel_i  - command fields
//               rsp_valid_o/rsp_ready_i     - response handshake
//               rsp_dat_o/rsp_err_o         - read data, timeout flag
//               wbm_*                       - Wishbone master port
//               busy_o                      - FSM not idle
// Revision    : 1.0 - initial release
// ============================================================================
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned ADR_W          = 32
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    // command
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [ADR_W-1:0] cmd_adr_i,
    input  logic [31:0]      cmd_dat_i,
    input  logic [3:0]       cmd_sel_i,
    // response
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_dat_o,
    output logic             rsp_err_o,
    // wishbone master
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [ADR_W-1:0] wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i,
    // status
    output logic             busy_o
);

    // Counter value at which the transfer is abandoned (count starts at 0 in
    // the first bus cycle, so TIMEOUT_CYCLES bus cycles elapse in total).
    localparam logic [c_CNT_W-1:0] c_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_armed;

    logic              w_cmd_ready;
    logic              w_accept;
    logic              w_bus;
    logic              w_rsp_valid;
    logic              w_ack_take;
    logic              w_to_take;
    logic              w_expired;

    logic              r_we;
    logic [ADR_W-1:0]  r_adr;
    logic [31:0]       r_dat;
    logic [3:0]        r_sel;
    logic [31:0]       r_rsp_dat;
    logic              r_rsp_err;

    // ------------------------------------------------------------------
    // State register. r_armed holds the command port closed for the first
    // cycle after reset so that cmd_ready_o is low throughout reset.
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_armed <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_accept    = 1'b0;
        w_bus       = 1'b0;
        w_rsp_valid = 1'b0;
        w_ack_take  = 1'b0;
        w_to_take   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = r_armed;
                if (cmd_valid_i && r_armed) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_BUS;
                end
            end
            ST_BUS: begin
                w_bus = 1'b1;
                // Ack is checked first so it wins over a coincident timeout.
                if (wbm_ack_i) begin
                    w_ack_take  = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (w_expired) begin
                    w_to_take   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                if (rsp_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request and response registers. Response fields only change on the
    // BUS exit edge, which keeps them stable for the whole RESP phase.
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_rsp_dat <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we  <= cmd_we_i;
                r_adr <= cmd_adr_i;
                r_dat <= cmd_dat_i;
                r_sel <= cmd_sel_i;
            end
            if (w_ack_take) begin
                r_rsp_dat <= r_we ? 32'h0 : wbm_dat_i;
                r_rsp_err <= 1'b0;
            end else if (w_to_take) begin
                r_rsp_dat <= c_TIMEOUT_DATA;
                r_rsp_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus-cycle timeout counter: cleared on accept, counts in BUS.
    // ------------------------------------------------------------------
    wb_timeout_cnt #(
        .CNT_W   (c_CNT_W)
    ) u_timeout_cnt (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clr     (w_accept),
        .en      (w_bus),
        .limit   (c_LIMIT),
        .expired (w_expired)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cmd_ready_o = w_cmd_ready;
    assign rsp_valid_o = w_rsp_valid;
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_err_o   = r_rsp_err;
    assign wbm_cyc_o   = w_bus;
    assign wbm_stb_o   = w_bus;
    assign wbm_we_o    = r_we;
    assign wbm_sel_o   = r_sel;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign busy_o      = (r_state != ST_IDLE);

endmodule : wb_cmd_master
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_cmd_master
// Description : Directed self-checking bench for wb_cmd_master with a small
//               Wishbone slave model and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_cmd_master;

    localparam int unsigned c_TO = 4;

    logic        clk;
    logic        wb_rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic [3:0]  cmd_sel_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        busy_o;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
    } rsp_t;

    rsp_t sb_q[$];

    int vectors = 0;
    int errors  = 0;

    // slave model controls
    int          ack_delay = 0;   // 0 = never ack, N = ack in Nth bus cycle
    logic        ack_force = 1'b0;
    logic [31:0] ack_dat   = 32'h0;
    int          bus_cnt   = 0;

    wb_cmd_master #(
        .TIMEOUT_CYCLES (c_TO),
        .ADR_W          (32)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (wb_rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_dat_i   (cmd_dat_i),
        .cmd_sel_i   (cmd_sel_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack_i),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: counts cycles of an active strobe and acks in cycle ack_delay.
    always @(posedge clk) begin
        if (wbm_cyc_o && wbm_stb_o) bus_cnt <= bus_cnt + 1;
        else                        bus_cnt <= 0;
    end

    assign wbm_ack_i = ack_force ||
                       (wbm_cyc_o && wbm_stb_o && (ack_delay != 0) && (bus_cnt == ack_delay - 1));
    assign wbm_dat_i = ack_dat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete command: issue, watch the bus phase, hold the response
    // for 'hold' cycles (optionally offering a second command), then drain.
    task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] exp_dat, input logic exp_err,
                           input int exp_bus, input int hold, input logic poke);
        int          bus_seen;
        int          wait_cnt;
        logic [31:0] held_dat;
        logic        held_err;
        rsp_t        exp;
        sb_q.push_back('{dat: exp_dat, err: exp_err});
        check("idle_cmd_ready", cmd_ready_o, 1);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        cmd_sel_i   = sel;
        @(negedge clk);
        // Scramble the command inputs to prove the fields were latched.
        cmd_valid_i = 1'b0;
        cmd_we_i    = ~we;
        cmd_adr_i   = $urandom;
        cmd_dat_i   = $urandom;
        cmd_sel_i   = ~sel;
        bus_seen = 0;
        wait_cnt = 0;
        while (!rsp_valid_o && wait_cnt < 50) begin
            if (wbm_cyc_o) begin
                bus_seen++;
                check("bus_stb", wbm_stb_o, 1);
                check("bus_we",  wbm_we_o,  we);
                check("bus_adr", wbm_adr_o, adr);
                check("bus_dat", wbm_dat_o, dat);
                check("bus_sel", wbm_sel_o, sel);
            end
            check("bus_busy", busy_o, 1);
            @(negedge clk);
            wait_cnt++;
        end
        check("rsp_arrived", rsp_valid_o, 1);
        check("bus_cycles", bus_seen, exp_bus);
        check("latency", wait_cnt + 1, exp_bus + 1);
        check("resp_cyc_low", wbm_cyc_o, 0);
        held_dat = rsp_dat_o;
        held_err = rsp_err_o;
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                cmd_valid_i = 1'b1;
                cmd_adr_i   = 32'h3000_00FC;
            end
            check("hold_valid", rsp_valid_o, 1);
            check("hold_cmd_ready", cmd_ready_o, 0);
            check("hold_dat", rsp_dat_o, held_dat);
            check("hold_err", rsp_err_o, held_err);
            @(negedge clk);
        end
        cmd_valid_i = 1'b0;
        check("resp_cmd_ready", cmd_ready_o, 0);
        rsp_ready_i = 1'b1;
        check("sb_nonempty", (sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check("rsp_dat", rsp_dat_o, exp.dat);
            check("rsp_err", rsp_err_o, exp.err);
        end
        @(negedge clk);
        rsp_ready_i = 1'b0;
        check("post_rsp_valid", rsp_valid_o, 0);
        check("post_busy", busy_o, 0);
        check("post_cmd_ready", cmd_ready_o, 1);
    endtask

    initial begin
        wb_rst_i    = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = 32'h0;
        cmd_dat_i   = 32'h0;
        cmd_sel_i   = 4'h0;
        rsp_ready_i = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_cmd_ready", cmd_ready_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_rsp_dat",   rsp_dat_o,   0);
        check("rst_rsp_err",   rsp_err_o,   0);
        check("rst_cyc",       wbm_cyc_o,   0);
        check("rst_stb",       wbm_stb_o,   0);
        check("rst_we",        wbm_we_o,    0);
        check("rst_adr",       wbm_adr_o,   0);
        check("rst_dat",       wbm_dat_o,   0);
        check("rst_sel",       wbm_sel_o,   0);
        check("rst_busy",      busy_o,      0);
        wb_rst_i = 1'b0;
        @(negedge clk);
        check("rst_release_ready", cmd_ready_o, 1);

        // stray ack while idle must be ignored
        ack_force = 1'b1;
        @(negedge clk);
        check("idle_ack_busy",  busy_o,      0);
        check("idle_ack_valid", rsp_valid_o, 0);
        ack_force = 1'b0;
        @(negedge clk);
        check("idle_ack_valid2", rsp_valid_o, 0);

        // write, ack in 3rd bus cycle: write data returns 0
        ack_delay = 3;
        ack_dat   = 32'hFFFF_0000;
        run_cmd(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 32'h0, 1'b0, 3, 0, 1'b0);

        // read, ack in first bus cycle
        ack_delay = 1;
        ack_dat   = 32'h1357_9BDF;
        run_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF, 32'h1357_9BDF, 1'b0, 1, 0, 1'b0);

        // timeout, no ack
        ack_delay = 0;
        ack_dat   = 32'h1111_2222;
        run_cmd(1'b0, 32'h3000_0010, 32'h0, 4'h1, 32'hDEAD_BEEF, 1'b1, c_TO, 0, 1'b0);

        // ack in the very cycle the timeout expires
        ack_delay = c_TO;
        ack_dat   = 32'h0BAD_F00D;
        run_cmd(1'b0, 32'h3000_0014, 32'h0, 4'hC, 32'h0BAD_F00D, 1'b0, c_TO, 0, 1'b0);

        // backpressure with a second command offered
        ack_delay = 2;
        ack_dat   = 32'hCAFE_0042;
        run_cmd(1'b0, 32'h3000_0018, 32'h0, 4'h3, 32'hCAFE_0042, 1'b0, 2, 5, 1'b1);

        // reset in the 2nd bus cycle
        ack_delay   = 0;
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b1;
        cmd_adr_i   = 32'h3000_0020;
        cmd_dat_i   = 32'h5555_AAAA;
        cmd_sel_i   = 4'h6;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        check("rstbus_cyc1", wbm_cyc_o, 1);
        @(negedge clk);
        check("rstbus_cyc2", wbm_cyc_o, 1);
        wb_rst_i = 1'b1;
        @(negedge clk);
        check("rstbus_cyc_drop",  wbm_cyc_o,   0);
        check("rstbus_stb_drop",  wbm_stb_o,   0);
        check("rstbus_valid",     rsp_valid_o, 0);
        check("rstbus_cmd_ready", cmd_ready_o, 0);
        check("rstbus_busy",      busy_o,      0);
        check("rstbus_adr",       wbm_adr_o,   0);
        wb_rst_i = 1'b0;
        @(negedge clk);
        check("rstbus_ready_rise", cmd_ready_o, 1);
        for (int i = 0; i < 3; i++) begin
            check("rstbus_no_rsp", rsp_valid_o, 0);
            @(negedge clk);
        end

        // recovery transfer after reset
        ack_delay = 1;
        ack_dat   = 32'h7777_8888;
        run_cmd(1'b1, 32'h3000_0024, 32'h0102_0304, 4'h9, 32'h0, 1'b0, 1, 1, 1'b0);

        check("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_wb_cmd_master
`default_nettype wire
